// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parameterised CRC generator/checker on a valid/ready
// beat stream. Each accepted beat is folded into the running register as
// DATA_W serial LFSR steps in one cycle; the frame's result is held on a
// valid/ready output until it is taken.
module crc_stream_engine #(
    parameter int unsigned CRC_W  = 8,
    parameter logic [63:0] POLY   = 64'h07,
    parameter logic [63:0] INIT   = 64'h0,
    parameter logic [63:0] XOROUT = 64'h0,
    parameter int unsigned DATA_W = 8,
    parameter bit          REFIN  = 1'b0,
    parameter bit          REFOUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_last,
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc,
    output logic              out_match,
    output logic              sop_err,
    output logic              busy
);

    localparam logic [CRC_W-1:0] POLY_C   = POLY[CRC_W-1:0];
    localparam logic [CRC_W-1:0] INIT_C   = INIT[CRC_W-1:0];
    localparam logic [CRC_W-1:0] XOROUT_C = XOROUT[CRC_W-1:0];

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state, state_nxt;
    logic [CRC_W-1:0]  r;
    logic [CRC_W-1:0]  seed;
    logic [CRC_W-1:0]  r_next;
    logic [CRC_W-1:0]  fin_crc;
    logic              accept;

    // Fold one beat into the register, one LFSR step per input bit.
    function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] s,
                                                  input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] v;
        logic             fb;
        v = s;
        for (int i = 0; i < int'(DATA_W); i++) begin
            fb = (REFIN ? d[i] : d[int'(DATA_W) - 1 - i]) ^ v[CRC_W-1];
            v  = (v << 1) ^ (fb ? POLY_C : '0);
        end
        return v;
    endfunction

    function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] o;
        for (int i = 0; i < int'(CRC_W); i++) o[i] = v[int'(CRC_W) - 1 - i];
        return o;
    endfunction

    // Beat datapath: a new frame (IDLE, or in_sop mid-frame) restarts from INIT.
    always_comb begin
        accept  = in_valid && in_ready;
        seed    = (state == IDLE || in_sop) ? INIT_C : r;
        r_next  = crc_beat(seed, in_data);
        fin_crc = (REFOUT ? bitrev(r_next) : r_next) ^ XOROUT_C;
    end

    // Next-state logic and handshake outputs; clr overrides everything.
    always_comb begin
        state_nxt = state;
        in_ready  = (state != DONE);
        busy      = (state != IDLE);
        case (state)
            IDLE, ACC: if (accept) state_nxt = in_last ? DONE : ACC;
            DONE:      if (out_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Running CRC, result capture and the mid-frame sop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= INIT_C;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_match <= 1'b0;
            sop_err   <= 1'b0;
        end else if (clr) begin
            r         <= INIT_C;
            out_valid <= 1'b0;
            sop_err   <= 1'b0;
        end else begin
            sop_err <= accept && (state == ACC) && in_sop;
            if (accept) begin
                r <= in_last ? INIT_C : r_next;
                if (in_last) begin
                    out_crc   <= fin_crc;
                    out_match <= (fin_crc == exp_crc);
                    out_valid <= 1'b1;
                end
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: three configurations (CRC-8, CRC-16/CCITT-FALSE,
// CRC-32 reflected) share one input stream and are checked against a bit-list
// reference model plus known check values.
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_sop = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  exp8 = '0;
    logic [15:0] exp16 = '0;
    logic [31:0] exp32 = '0;

    logic        rdy8, ov8, mt8, se8, bz8;
    logic [7:0]  crc8;
    logic        rdy16, ov16, mt16, se16, bz16;
    logic [15:0] crc16;
    logic        rdy32, ov32, mt32, se32, bz32;
    logic [31:0] crc32;

    int checks = 0;
    int failures = 0;
    int sop_cnt = 0;

    always #5 clk = ~clk;

    crc_stream_engine #(.CRC_W(8), .POLY(64'h07)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy8),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last), .exp_crc(exp8),
        .out_valid(ov8), .out_ready(out_ready), .out_crc(crc8), .out_match(mt8),
        .sop_err(se8), .busy(bz8));

    crc_stream_engine #(.CRC_W(16), .POLY(64'h1021), .INIT(64'hFFFF)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy16),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last), .exp_crc(exp16),
        .out_valid(ov16), .out_ready(out_ready), .out_crc(crc16), .out_match(mt16),
        .sop_err(se16), .busy(bz16));

    crc_stream_engine #(.CRC_W(32), .POLY(64'h04C11DB7), .INIT(64'hFFFFFFFF),
                        .XOROUT(64'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy32),
        .in_data(in_data), .in_sop(in_sop), .in_last(in_last), .exp_crc(exp32),
        .out_valid(ov32), .out_ready(out_ready), .out_crc(crc32), .out_match(mt32),
        .sop_err(se32), .busy(bz32));

    // Reference: the message as one bit sequence divided by the polynomial.
    function automatic logic [63:0] ref_crc(int w, logic [63:0] poly, logic [63:0] init,
                                            logic [63:0] xo, bit ri, bit ro, byte q[$]);
        logic [63:0] mask, r, o;
        bit          b[$];
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        foreach (q[k]) for (int j = 0; j < 8; j++) b.push_back(ri ? q[k][j] : q[k][7-j]);
        r = init & mask;
        foreach (b[k]) r = (((r << 1) & mask) ^ ((b[k] ^ r[w-1]) ? poly : 64'd0)) & mask;
        o = r;
        if (ro) begin
            o = '0;
            for (int j = 0; j < w; j++) o[j] = r[w-1-j];
        end
        return (o ^ xo) & mask;
    endfunction

    function automatic logic [63:0] m8(byte q[$]);
        return ref_crc(8, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0, q);
    endfunction
    function automatic logic [63:0] m16(byte q[$]);
        return ref_crc(16, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 1'b0, q);
    endfunction
    function automatic logic [63:0] m32(byte q[$]);
        return ref_crc(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, q);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (se8) sop_cnt++;
    endtask

    task automatic send_beat(logic [7:0] d, bit sop, bit last);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_sop = sop; in_last = last;
        while (!rdy8 && n < 50) begin tick(); n++; end
        if (n == 50) check("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(byte q[$], bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_beat(q[i], i == 0, i == q.size() - 1);
        end
    endtask

    // Wait for the result, compare all three engines to the model, then take it.
    task automatic expect_all(string tag, byte q[$], bit rnd_delay);
        int n = 0;
        logic [63:0] e8, e16, e32;
        e8 = m8(q); e16 = m16(q); e32 = m32(q);
        while (!ov8 && n < 20) begin tick(); n++; end
        check({tag, "_valid"}, {61'd0, ov8, ov16, ov32}, 64'd7);
        check({tag, "_crc8"}, {56'd0, crc8}, e8);
        check({tag, "_crc16"}, {48'd0, crc16}, e16);
        check({tag, "_crc32"}, {32'd0, crc32}, e32);
        check({tag, "_match"}, {61'd0, mt8, mt16, mt32},
              {61'd0, e8[7:0] == exp8, e16[15:0] == exp16, e32[31:0] == exp32});
        if (rnd_delay) repeat ($urandom_range(0, 2)) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle"}, {62'd0, ov8, rdy8}, 64'd1);
    endtask

    typedef struct {
        logic [71:0] msg;
        int          len;
        logic [7:0]  xin;
        logic [7:0]  e8;
        bit          match;
    } vec_t;

    function automatic void to_q(logic [71:0] msg, int len, output byte q[$]);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(byte'(msg[8*(len-1-i) +: 8]));
    endfunction

    initial begin
        vec_t vecs[5];
        byte  q[$];
        byte  s12[$];
        byte  s9[$];

        vecs[0] = '{72'h313233343536373839, 9, 8'hF4, 8'hF4, 1'b1};
        vecs[1] = '{72'h01,                 1, 8'h07, 8'h07, 1'b1};
        vecs[2] = '{72'h00,                 1, 8'h55, 8'h00, 1'b0};
        vecs[3] = '{72'h31,                 1, 8'h97, 8'h97, 1'b1};
        vecs[4] = '{72'h3132,               2, 8'h00, 8'h72, 1'b0};
        to_q(72'h313233343536373839, 9, s9);
        to_q(72'h3132, 2, s12);

        // Reset values
        tick(); tick();
        check("rst_outs", {56'd0, ov8, crc8[6:0]}, 64'd0);
        check("rst_flags", {59'd0, mt8, se8, bz8, rdy8, ov32}, 64'd2);
        check("rst_crc32", {32'd0, crc32}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors: fixed CRC-8 results plus known check values.
        foreach (vecs[v]) begin
            to_q(vecs[v].msg, vecs[v].len, q);
            exp8 = vecs[v].xin; exp16 = m16(q); exp32 = m32(q);
            send_frame(q, 1'b0);
            check($sformatf("vec%0d_latency", v), {62'd0, ov8, rdy8}, 64'd2);
            check($sformatf("vec%0d_crc8", v), {56'd0, crc8}, {56'd0, vecs[v].e8});
            check($sformatf("vec%0d_match8", v), {63'd0, mt8}, {63'd0, vecs[v].match});
            if (v == 0) begin
                check("check_crc16", {48'd0, crc16}, 64'h29B1);
                check("check_crc32", {32'd0, crc32}, 64'hCBF43926);
            end
            expect_all($sformatf("vec%0d", v), q, 1'b0);
        end

        // Backpressure: result held, a pending beat must wait for IDLE.
        exp8 = 8'hF4; exp16 = m16(s9); exp32 = m32(s9);
        send_frame(s9, 1'b0);
        in_valid = 1'b1; in_data = 8'hAA; in_sop = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold%0d", i), {51'd0, ov8, rdy8, crc8, mt8, bz8}, {51'd0, 1'b1, 1'b0, 8'hF4, 1'b1, 1'b1});
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {62'd0, ov8, rdy8}, 64'd1);
        tick();
        in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0;
        q = {8'hAA};
        expect_all("bp_next", q, 1'b0);

        // Mid-frame sop restarts the frame and pulses sop_err once.
        exp8 = 8'hF4; exp16 = m16(s9); exp32 = m32(s9);
        sop_cnt = 0;
        send_beat(8'h31, 1'b1, 1'b0);
        send_beat(8'h32, 1'b0, 1'b0);
        send_frame(s9, 1'b0);
        tick();
        check("sop_err_count", sop_cnt, 1);
        check("sop_err_others", {62'd0, se16, se32}, 64'd0);
        expect_all("midsop", s9, 1'b0);

        // clr while accumulating.
        send_beat(8'h31, 1'b1, 1'b0);
        send_beat(8'h32, 1'b0, 1'b0);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_acc", {62'd0, ov8, bz8}, 64'd0);
        send_frame(s9, 1'b0);
        expect_all("after_clr_acc", s9, 1'b0);

        // clr while the result is pending: valid drops, value kept.
        send_frame(s9, 1'b0);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_done", {53'd0, ov8, bz8, rdy8, crc8}, {53'd0, 1'b0, 1'b0, 1'b1, 8'hF4});
        tick();
        check("clr_done_stays", {63'd0, ov8}, 64'd0);
        q = {8'h31};
        exp8 = 8'h97;
        send_frame(q, 1'b0);
        expect_all("after_clr_done", q, 1'b0);

        // Asynchronous reset mid-frame.
        send_beat(8'h31, 1'b1, 1'b0);
        send_beat(8'h32, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_outs", {48'd0, ov8, bz8, rdy8, mt8, se8, crc8, 3'd0}, {48'd0, 5'b00100, 11'd0});
        check("arst_crc16", {48'd0, crc16}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(s9, 1'b0);
        exp8 = 8'h00;
        expect_all("after_arst", s9, 1'b0);

        // Randomized frames with gaps and output backpressure.
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 6);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(byte'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) != 0) begin
                exp8 = m8(q); exp16 = m16(q); exp32 = m32(q);
            end else begin
                exp8 = 8'($urandom); exp16 = 16'($urandom); exp32 = $urandom;
            end
            send_frame(q, 1'b1);
            expect_all($sformatf("rnd%0d", f), q, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
